// File: rtl/ev22_register_bank.sv
// ----------------------------------------------------------------------------
// ev22_register_bank
//
// Architectural register storage for the EV22 datapath. Every stored value is
// continuously visible on an output, so the operand-select stage downstream
// can pick any source without a read port.
//
// Ports:
//   clk              system clock, all state changes on the rising edge
//   rst_n            asynchronous active-low reset
//   wr_en            write-back request from the instruction path
//   wr_sel           write-back destination (0..27 GPR, 32/33 PO, 34 working)
//   wr_data          write-back data
//   wreg_en          ALU write to the working register (r34)
//   wreg_data        ALU result
//   pi0, pi1         asynchronous external input ports
//   r0..r27          general registers
//   r28, r29         synchronised PI0 / PI1 (read-only)
//   r32, r33         output-port registers PO0 / PO1
//   working_register r34
//   updateBlock      one-cycle strobe: a register committed on the last edge
//   wr_err           one-cycle strobe: the last edge's write-back was rejected
// ----------------------------------------------------------------------------
module ev22_register_bank #(
    parameter int               WIDTH       = 16,
    parameter int               SYNC_STAGES = 2,   // legal range 2..4
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [5:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wreg_en,
    input  logic [WIDTH-1:0] wreg_data,
    input  logic [WIDTH-1:0] pi0,
    input  logic [WIDTH-1:0] pi1,
    output logic [WIDTH-1:0] r0,  r1,  r2,  r3,  r4,  r5,  r6,
    output logic [WIDTH-1:0] r7,  r8,  r9,  r10, r11, r12, r13,
    output logic [WIDTH-1:0] r14, r15, r16, r17, r18, r19, r20,
    output logic [WIDTH-1:0] r21, r22, r23, r24, r25, r26, r27,
    output logic [WIDTH-1:0] r28,
    output logic [WIDTH-1:0] r29,
    output logic [WIDTH-1:0] r32,
    output logic [WIDTH-1:0] r33,
    output logic [WIDTH-1:0] working_register,
    output logic             updateBlock,
    output logic             wr_err
);

    logic [WIDTH-1:0] gpr_q [28];
    logic [WIDTH-1:0] po0_q;
    logic [WIDTH-1:0] po1_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] pi0Sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] pi1Sync_q [SYNC_STAGES];
    logic             update_q;
    logic             wrErr_q;

    logic             wbValid;
    logic             wbCommit;
    logic             update_d;
    logic             wrErr_d;

    // Address decode for the write-back path. A write-back aimed at r34 on
    // the same edge as an ALU write loses silently: it is neither committed
    // nor flagged as an error.
    always_comb begin
        wbValid  = (wr_sel < 6'd28) || ((wr_sel >= 6'd32) && (wr_sel <= 6'd34));
        wbCommit = wr_en && wbValid && !(wreg_en && (wr_sel == 6'd34));
        wrErr_d  = wr_en && !wbValid;
        update_d = wbCommit || wreg_en;
    end

    // Architectural registers plus the two status strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 28; i++) begin
                gpr_q[i] <= RESET_VALUE;
            end
            po0_q    <= RESET_VALUE;
            po1_q    <= RESET_VALUE;
            work_q   <= RESET_VALUE;
            update_q <= 1'b0;
            wrErr_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 28; i++) begin
                if (wbCommit && (wr_sel == 6'(i))) begin
                    gpr_q[i] <= wr_data;
                end
            end
            if (wbCommit && (wr_sel == 6'd32)) begin
                po0_q <= wr_data;
            end
            if (wbCommit && (wr_sel == 6'd33)) begin
                po1_q <= wr_data;
            end
            if (wreg_en) begin
                work_q <= wreg_data;
            end else if (wbCommit && (wr_sel == 6'd34)) begin
                work_q <= wr_data;
            end
            update_q <= update_d;
            wrErr_q  <= wrErr_d;
        end
    end

    // Input-port synchronisers; the last stage is the architectural r28/r29.
    // These never touch updateBlock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                pi0Sync_q[i] <= RESET_VALUE;
                pi1Sync_q[i] <= RESET_VALUE;
            end
        end else begin
            pi0Sync_q[0] <= pi0;
            pi1Sync_q[0] <= pi1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pi0Sync_q[i] <= pi0Sync_q[i-1];
                pi1Sync_q[i] <= pi1Sync_q[i-1];
            end
        end
    end

    assign r0  = gpr_q[0];
    assign r1  = gpr_q[1];
    assign r2  = gpr_q[2];
    assign r3  = gpr_q[3];
    assign r4  = gpr_q[4];
    assign r5  = gpr_q[5];
    assign r6  = gpr_q[6];
    assign r7  = gpr_q[7];
    assign r8  = gpr_q[8];
    assign r9  = gpr_q[9];
    assign r10 = gpr_q[10];
    assign r11 = gpr_q[11];
    assign r12 = gpr_q[12];
    assign r13 = gpr_q[13];
    assign r14 = gpr_q[14];
    assign r15 = gpr_q[15];
    assign r16 = gpr_q[16];
    assign r17 = gpr_q[17];
    assign r18 = gpr_q[18];
    assign r19 = gpr_q[19];
    assign r20 = gpr_q[20];
    assign r21 = gpr_q[21];
    assign r22 = gpr_q[22];
    assign r23 = gpr_q[23];
    assign r24 = gpr_q[24];
    assign r25 = gpr_q[25];
    assign r26 = gpr_q[26];
    assign r27 = gpr_q[27];

    assign r28              = pi0Sync_q[SYNC_STAGES-1];
    assign r29              = pi1Sync_q[SYNC_STAGES-1];
    assign r32              = po0_q;
    assign r33              = po1_q;
    assign working_register = work_q;
    assign updateBlock      = update_q;
    assign wr_err           = wrErr_q;

endmodule

// File: tb/tb_ev22_register_bank.sv
// ----------------------------------------------------------------------------
// tb_ev22_register_bank
//
// Directed bench for ev22_register_bank with hand-computed expectations.
// Inputs are driven away from the rising edge and outputs are sampled 1 ns
// after it.
// ----------------------------------------------------------------------------
module tb_ev22_register_bank;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [5:0]  wr_sel;
    logic [15:0] wr_data;
    logic        wreg_en;
    logic [15:0] wreg_data;
    logic [15:0] pi0;
    logic [15:0] pi1;
    logic [15:0] rOut [28];
    logic [15:0] r28, r29, r32, r33, workReg;
    logic        updateBlock;
    logic        wr_err;

    int checks = 0;
    int errors = 0;
    int badSel [7] = '{28, 29, 30, 31, 35, 40, 63};

    ev22_register_bank #(
        .WIDTH       (16),
        .SYNC_STAGES (2),
        .RESET_VALUE (16'h0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_en            (wr_en),
        .wr_sel           (wr_sel),
        .wr_data          (wr_data),
        .wreg_en          (wreg_en),
        .wreg_data        (wreg_data),
        .pi0              (pi0),
        .pi1              (pi1),
        .r0  (rOut[0]),  .r1  (rOut[1]),  .r2  (rOut[2]),  .r3  (rOut[3]),
        .r4  (rOut[4]),  .r5  (rOut[5]),  .r6  (rOut[6]),  .r7  (rOut[7]),
        .r8  (rOut[8]),  .r9  (rOut[9]),  .r10 (rOut[10]), .r11 (rOut[11]),
        .r12 (rOut[12]), .r13 (rOut[13]), .r14 (rOut[14]), .r15 (rOut[15]),
        .r16 (rOut[16]), .r17 (rOut[17]), .r18 (rOut[18]), .r19 (rOut[19]),
        .r20 (rOut[20]), .r21 (rOut[21]), .r22 (rOut[22]), .r23 (rOut[23]),
        .r24 (rOut[24]), .r25 (rOut[25]), .r26 (rOut[26]), .r27 (rOut[27]),
        .r28              (r28),
        .r29              (r29),
        .r32              (r32),
        .r33              (r33),
        .working_register (workReg),
        .updateBlock      (updateBlock),
        .wr_err           (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fill every writable register with FFFF, then pull reset mid-cycle with
    // a write still pending and confirm everything clears without an edge.
    task automatic test_reset();
        pi0 = 16'hFFFF;
        pi1 = 16'hFFFF;
        for (int a = 0; a < 35; a++) begin
            if (a < 28 || a > 31) begin
                @(negedge clk);
                wr_en   = 1'b1;
                wr_sel  = 6'(a);
                wr_data = 16'hFFFF;
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 28; i++) begin
            checks++;
            if (rOut[i] !== 16'hFFFF) begin
                errors++;
                $display("[TB] FAIL load_r%0d: got %h expected ffff", i, rOut[i]);
            end
        end
        checks++;
        if ({r28, r29, r32, r33, workReg} !== {5{16'hFFFF}}) begin
            errors++;
            $display("[TB] FAIL load_upper: got %h %h %h %h %h expected all ffff",
                     r28, r29, r32, r33, workReg);
        end
        checks++;
        if (updateBlock !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_update: got %b expected 1", updateBlock);
        end
        #2;
        wr_sel  = 6'd10;
        wr_data = 16'h5555;
        rst_n   = 1'b0;
        #1;
        for (int i = 0; i < 28; i++) begin
            checks++;
            if (rOut[i] !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL async_reset_r%0d: got %h expected 0000", i, rOut[i]);
            end
        end
        checks++;
        if ({r28, r29, r32, r33, workReg} !== 80'h0) begin
            errors++;
            $display("[TB] FAIL async_reset_upper: got %h %h %h %h %h expected all 0000",
                     r28, r29, r32, r33, workReg);
        end
        checks++;
        if ({updateBlock, wr_err} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL async_reset_strobes: got %b%b expected 00", updateBlock, wr_err);
        end
        @(negedge clk);
        pi0 = 16'h0000;
        pi1 = 16'h0000;
        @(posedge clk); #1;
        checks++;
        if (rOut[10] !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_discard: got %h expected 0000", rOut[10]);
        end
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({updateBlock, rOut[10]} !== 17'h0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got upd=%b r10=%h expected 0 0000",
                     updateBlock, rOut[10]);
        end
    endtask

    // Single write-backs to a general register and to an output port.
    task automatic test_basic_write();
        @(negedge clk);
        wr_en = 1'b1; wr_sel = 6'd5; wr_data = 16'hA5A5;
        @(posedge clk); #1;
        wr_en = 1'b0;
        checks++;
        if ({rOut[5], updateBlock, wr_err} !== {16'hA5A5, 2'b10}) begin
            errors++;
            $display("[TB] FAIL write_r5: got r5=%h upd=%b err=%b expected a5a5 1 0",
                     rOut[5], updateBlock, wr_err);
        end
        checks++;
        if ({rOut[4], rOut[6]} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL write_r5_neighbours: got %h %h expected 0000 0000", rOut[4], rOut[6]);
        end
        @(posedge clk); #1;
        checks++;
        if ({rOut[5], updateBlock} !== {16'hA5A5, 1'b0}) begin
            errors++;
            $display("[TB] FAIL write_r5_hold: got r5=%h upd=%b expected a5a5 0", rOut[5], updateBlock);
        end
        wr_en = 1'b1; wr_sel = 6'd32; wr_data = 16'h1234;
        @(posedge clk); #1;
        wr_en = 1'b0;
        checks++;
        if ({r32, r33, updateBlock, wr_err} !== {16'h1234, 16'h0000, 2'b10}) begin
            errors++;
            $display("[TB] FAIL write_r32: got r32=%h r33=%h upd=%b err=%b expected 1234 0000 1 0",
                     r32, r33, updateBlock, wr_err);
        end
        @(posedge clk); #1;
        checks++;
        if (updateBlock !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_r32_pulse: got %b expected 0", updateBlock);
        end
    endtask

    // Write-backs to read-only and unmapped addresses are dropped and flagged.
    task automatic test_rejected_write();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_sel = 6'(badSel[k]); wr_data = 16'hDEAD;
            @(posedge clk); #1;
            wr_en = 1'b0;
            checks++;
            if ({wr_err, updateBlock} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL reject_%0d_strobes: got err=%b upd=%b expected 1 0",
                         badSel[k], wr_err, updateBlock);
            end
            checks++;
            if ({r28, r29, r32, r33, workReg, rOut[3], rOut[8]} !==
                {16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000}) begin
                errors++;
                $display("[TB] FAIL reject_%0d_state: got %h %h %h %h %h %h %h expected 0 0 1234 0 0 0 0",
                         badSel[k], r28, r29, r32, r33, workReg, rOut[3], rOut[8]);
            end
            @(posedge clk); #1;
            checks++;
            if (wr_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reject_%0d_pulse: got %b expected 0", badSel[k], wr_err);
            end
        end
    endtask

    // ALU write and write-back both aimed at r34: the ALU wins, no error.
    task automatic test_collision();
        @(negedge clk);
        wr_en = 1'b1; wr_sel = 6'd34; wr_data = 16'h1111;
        wreg_en = 1'b1; wreg_data = 16'h2222;
        @(posedge clk); #1;
        wr_en = 1'b0; wreg_en = 1'b0;
        checks++;
        if ({workReg, wr_err, updateBlock} !== {16'h2222, 2'b01}) begin
            errors++;
            $display("[TB] FAIL collision: got r34=%h err=%b upd=%b expected 2222 0 1",
                     workReg, wr_err, updateBlock);
        end
        @(posedge clk); #1;
        checks++;
        if ({workReg, updateBlock} !== {16'h2222, 1'b0}) begin
            errors++;
            $display("[TB] FAIL collision_hold: got r34=%h upd=%b expected 2222 0", workReg, updateBlock);
        end
    endtask

    // ALU write and write-back to different registers on one edge.
    task automatic test_independent();
        @(negedge clk);
        wr_en = 1'b1; wr_sel = 6'd7; wr_data = 16'h7777;
        wreg_en = 1'b1; wreg_data = 16'h0F0F;
        @(posedge clk); #1;
        wr_en = 1'b0; wreg_en = 1'b0;
        checks++;
        if ({workReg, rOut[7], updateBlock, wr_err} !== {16'h0F0F, 16'h7777, 2'b10}) begin
            errors++;
            $display("[TB] FAIL independent: got r34=%h r7=%h upd=%b err=%b expected 0f0f 7777 1 0",
                     workReg, rOut[7], updateBlock, wr_err);
        end
        @(posedge clk); #1;
        checks++;
        if (updateBlock !== 1'b0) begin
            errors++;
            $display("[TB] FAIL independent_pulse: got %b expected 0", updateBlock);
        end
    endtask

    // Consecutive commits keep updateBlock high; a rejected write drops it.
    task automatic test_back_to_back();
        logic [5:0]  seqSel  [3];
        logic [15:0] seqData [3];
        seqSel[0] = 6'd0;  seqData[0] = 16'h0001;
        seqSel[1] = 6'd1;  seqData[1] = 16'h0002;
        seqSel[2] = 6'd33; seqData[2] = 16'h0033;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1; wr_sel = seqSel[k]; wr_data = seqData[k];
            @(posedge clk); #1;
            checks++;
            if (updateBlock !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_update_%0d: got %b expected 1", k, updateBlock);
            end
        end
        wr_sel = 6'd30; wr_data = 16'hBAD0;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wreg_en = 1'b1; wreg_data = 16'h4444;
        checks++;
        if ({updateBlock, wr_err} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL b2b_reject: got upd=%b err=%b expected 0 1", updateBlock, wr_err);
        end
        @(posedge clk); #1;
        wreg_en = 1'b0;
        checks++;
        if ({updateBlock, wr_err, workReg} !== {2'b10, 16'h4444}) begin
            errors++;
            $display("[TB] FAIL b2b_alu: got upd=%b err=%b r34=%h expected 1 0 4444",
                     updateBlock, wr_err, workReg);
        end
        checks++;
        if ({rOut[0], rOut[1], r33} !== {16'h0001, 16'h0002, 16'h0033}) begin
            errors++;
            $display("[TB] FAIL b2b_values: got %h %h %h expected 0001 0002 0033", rOut[0], rOut[1], r33);
        end
        @(posedge clk); #1;
        checks++;
        if (updateBlock !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: got %b expected 0", updateBlock);
        end
    endtask

    // Input ports take exactly two edges to reach r28/r29.
    task automatic test_sync();
        @(negedge clk);
        pi0 = 16'h1357;
        pi1 = 16'hBEEF;
        @(posedge clk); #1;
        checks++;
        if ({r28, r29, updateBlock} !== {32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sync_edge1: got r28=%h r29=%h upd=%b expected 0000 0000 0",
                     r28, r29, updateBlock);
        end
        @(posedge clk); #1;
        checks++;
        if ({r28, r29, updateBlock} !== {16'h1357, 16'hBEEF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sync_edge2: got r28=%h r29=%h upd=%b expected 1357 beef 0",
                     r28, r29, updateBlock);
        end
        @(posedge clk); #1;
        checks++;
        if ({r29, updateBlock} !== {16'hBEEF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sync_edge3: got r29=%h upd=%b expected beef 0", r29, updateBlock);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_sel    = 6'd0;
        wr_data   = 16'h0000;
        wreg_en   = 1'b0;
        wreg_data = 16'h0000;
        pi0       = 16'h0000;
        pi1       = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_basic_write();
        test_rejected_write();
        test_collision();
        test_independent();
        test_back_to_back();
        test_sync();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ev22_register_bank.md
Name: ev22_register_bank

Overview:
- Architectural register storage for the EV22 datapath.
- Sits directly upstream of the operand-select stage and drives every source that stage selects from:
  - r0..r27 general registers
  - r28/r29 synchronised input ports PI0/PI1
  - r32/r33 output-port registers
  - r34 working register
- Accepts one write-back per clock from the instruction path plus one working-register update from the ALU.
- Emits a one-cycle update strobe that tells the operand-select stage the bank has changed.

Parameters:
- WIDTH, 16: data width of every register and port.
- SYNC_STAGES, 2: flip-flop depth of the PI0/PI1 input synchronisers. Legal values are 2..4.
- RESET_VALUE, 16'h0000: value loaded into every register at reset.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write-back request.
- wr_sel  input  6  write-back destination address, using the register numbering given under Behaviour.
- wr_data  input  WIDTH  write-back data.
- wreg_en  input  1  ALU result write to the working register (r34).
- wreg_data  input  WIDTH  ALU result.
- pi0  input  WIDTH  asynchronous external input port 0.
- pi1  input  WIDTH  asynchronous external input port 1.
- r0..r27  output  WIDTH each  general register contents.
- r28  output  WIDTH  synchronised PI0.
- r29  output  WIDTH  synchronised PI1.
- r32  output  WIDTH  output-port register PO0; also drives the PO0 pins.
- r33  output  WIDTH  output-port register PO1; also drives the PO1 pins.
- working_register  output  WIDTH  r34.
- updateBlock  output  1  one-cycle strobe: at least one register committed a write on the previous edge.
- wr_err  output  1  one-cycle strobe: the previous edge's write-back was rejected.

Behaviour:
- Reset (rst_n low):
  - Applies immediately, independent of clk.
  - All registers, all synchroniser flops, updateBlock and wr_err go to RESET_VALUE / 0.
  - An in-flight write is discarded.
  - First write is accepted on the first rising edge after rst_n rises.
- Register map:
  - 0..27: general registers.
  - 28, 29: read-only.
  - 30, 31: unmapped.
  - 32, 33: output-port registers.
  - 34: working register.
  - 35..63: unmapped.
- Write-back (wr_en=1 at an edge):
  - wr_sel in {0..27, 32, 33, 34}: wr_data is stored. The new value is visible on the output the cycle after the edge (1-cycle latency).
  - wr_sel in {28, 29, 30, 31, 35..63}: nothing is stored and wr_err=1 for exactly the next cycle.
- ALU write (wreg_en=1 at an edge): wreg_data is stored into r34.
- Simultaneous writes: if wr_en=1 with wr_sel=34 and wreg_en=1 on the same edge:
  - wreg_data wins.
  - The write-back is silently dropped; wr_err stays 0.
- Writes to different registers on the same edge both commit.
- updateBlock:
  - Registered output.
  - Equals 1 for the cycle after any edge where wr_en or wreg_en committed at least one register; otherwise 0.
  - Rejected writes do not raise it.
  - Back-to-back commits hold it high continuously.
- Input synchronisers:
  - pi0/pi1 pass through a SYNC_STAGES flop chain; r28/r29 are the last stage.
  - A stable input change appears on r28/r29 exactly SYNC_STAGES edges later.
  - Synchroniser changes never raise updateBlock.
- No read port exists: all stored state is continuously visible on the outputs.
- Outputs change only on clk edges or on assertion of rst_n.

Test Plan:
- Reset: load all registers to 16'hFFFF, assert rst_n low mid-cycle -> all outputs are 0 immediately, before the next edge; updateBlock=0.
- Basic write: wr_en=1, wr_sel=5, wr_data=16'hA5A5 for one edge -> next cycle r5=16'hA5A5 and updateBlock=1 for one cycle. Repeat for wr_sel=32 with 16'h1234 -> r32=16'h1234.
- Rejected write: wr_en=1, wr_sel=28, wr_data=16'hDEAD -> r28 unchanged, wr_err=1 for one cycle, updateBlock=0. Repeat for wr_sel=30 and wr_sel=40 with the same result.
- Write collision: wr_en=1, wr_sel=34, wr_data=16'h1111 and wreg_en=1, wreg_data=16'h2222 on the same edge -> working_register=16'h2222, wr_err=0, updateBlock=1.
- Independent writes: wreg_en=1 with 16'h0F0F and wr_sel=7 with 16'h7777 on the same edge -> both commit; updateBlock is a single 1-cycle pulse.
- Synchroniser latency: pi1 steps 0 -> 16'hBEEF, held stable -> r29 reads 0 for the first edge and 16'hBEEF after the 2nd edge (SYNC_STAGES=2); updateBlock stays 0 throughout.
